// File: rtl/rx_core_cfg_ctrl.sv
// Configuration sequencer: shadows rx_core tuning words and applies them atomically
// behind a mute/settle window. Define RX_CFG_MUTE_EN to enable the MUTE phase and dac_mute.
module rx_core_cfg_ctrl #(
  parameter int unsigned MUTE_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        commit,
  output logic [15:0] ddc_phase_inc,
  output logic [15:0] demix_phase_inc,
  output logic [15:0] duc_phase_inc,
  output logic [15:0] lpf1_gain,
  output logic [15:0] lpf2_gain,
  output logic [15:0] lpf3_gain,
  output logic [15:0] lpf4_gain,
  output logic        dac_mute,
  output logic        busy,
  output logic        cfg_done,
  output logic [7:0]  commit_count
);

  localparam logic [15:0] MuteLoad   = 16'(MUTE_CYCLES - 1);
  localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StMute, StApply, StSettle} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        done_d;
  logic        cfg_ready_q, busy_q, mute_q, done_q;
  logic [7:0]  count_q;
  logic [15:0] shadow_q [7];
  logic [15:0] active_q [7];
  logic        wr_en;

  assign wr_en = cfg_valid && cfg_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    case (state_q)
      StIdle: begin
        if (commit || pending_q) begin
          pending_d = 1'b0;
`ifdef RX_CFG_MUTE_EN
          state_d   = StMute;
          cnt_d     = MuteLoad;
`else
          state_d   = StApply;
`endif
        end
      end
      StMute: begin
        if (commit) pending_d = 1'b1;
        if (cnt_q == 16'd0) state_d = StApply;
        else                cnt_d   = cnt_q - 16'd1;
      end
      StApply: begin
        if (commit) pending_d = 1'b1;
        state_d = StSettle;
        cnt_d   = SettleLoad;
      end
      StSettle: begin
        if (commit) pending_d = 1'b1;
        if (cnt_q == 16'd0) state_d = StIdle;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = StIdle;
    endcase
    // Flag the final SETTLE cycle one edge early so cfg_done can be a registered output.
    done_d = (state_d == StSettle) && (cnt_d == 16'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      mute_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      cfg_ready_q <= (state_d != StApply);
      busy_q      <= (state_d != StIdle);
`ifdef RX_CFG_MUTE_EN
      mute_q      <= (state_d != StIdle);
`else
      mute_q      <= 1'b0;
`endif
      done_q      <= done_d;
      if (done_d) count_q <= count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (wr_en && (cfg_addr == 3'(i))) shadow_q[i] <= cfg_data;
      end
      if (state_q == StApply) active_q <= shadow_q;
    end
  end

  assign cfg_ready       = cfg_ready_q;
  assign busy            = busy_q;
  assign dac_mute        = mute_q;
  assign cfg_done        = done_q;
  assign commit_count    = count_q;
  assign ddc_phase_inc   = active_q[0];
  assign demix_phase_inc = active_q[1];
  assign duc_phase_inc   = active_q[2];
  assign lpf1_gain       = active_q[3];
  assign lpf2_gain       = active_q[4];
  assign lpf3_gain       = active_q[5];
  assign lpf4_gain       = active_q[6];

endmodule
